// File: rtl/proc_mem_port_arbiter.sv
// Round-robin sharing of one 4B memory port between instruction-fetch and data
// requesters; an ordering FIFO of requester ids steers in-order responses back.
module proc_mem_port_arbiter #(
    parameter int unsigned p_max_inflight = 4,
    parameter int unsigned p_id_bits      = $clog2(p_max_inflight) + 1
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic [76:0]          imemreq_msg,
    input  logic                 imemreq_val,
    output logic                 imemreq_rdy,
    output logic [46:0]          imemresp_msg,
    output logic                 imemresp_val,
    input  logic                 imemresp_rdy,

    input  logic [76:0]          dmemreq_msg,
    input  logic                 dmemreq_val,
    output logic                 dmemreq_rdy,
    output logic [46:0]          dmemresp_msg,
    output logic                 dmemresp_val,
    input  logic                 dmemresp_rdy,

    output logic [76:0]          memreq_msg,
    output logic                 memreq_val,
    input  logic                 memreq_rdy,
    input  logic [46:0]          memresp_msg,
    input  logic                 memresp_val,
    output logic                 memresp_rdy,

    output logic [p_id_bits-1:0] inflight_count
);

    localparam int unsigned PtrBits = $clog2(p_max_inflight);

    typedef enum logic {
        REQ_IMEM = 1'b0,
        REQ_DMEM = 1'b1
    } req_id_e;

    req_id_e                   prio_q,  prio_d;
    logic [p_max_inflight-1:0] owner_q, owner_d;
    logic [PtrBits-1:0]        head_q,  head_d;
    logic [PtrBits-1:0]        tail_q,  tail_d;
    logic [p_id_bits-1:0]      count_q, count_d;

    logic    fifo_full, fifo_empty;
    logic    grant_imem, grant_dmem;
    logic    req_fire, resp_fire;
    req_id_e head_id;

    assign fifo_full  = (count_q == p_id_bits'(p_max_inflight));
    assign fifo_empty = (count_q == '0);
    assign head_id    = req_id_e'(owner_q[head_q]);

    // Grant looks only at the registered count, so a pop never opens issue in the same cycle.
    always_comb begin
        grant_imem = 1'b0;
        grant_dmem = 1'b0;
        if (!reset && !fifo_full) begin
            if (imemreq_val && dmemreq_val) begin
                if (prio_q == REQ_DMEM) grant_dmem = 1'b1;
                else                    grant_imem = 1'b1;
            end else begin
                grant_imem = imemreq_val;
                grant_dmem = dmemreq_val;
            end
        end
    end

    assign memreq_val  = grant_imem | grant_dmem;
    assign memreq_msg  = grant_imem ? imemreq_msg : dmemreq_msg;
    assign imemreq_rdy = grant_imem & memreq_rdy;
    assign dmemreq_rdy = grant_dmem & memreq_rdy;
    assign req_fire    = memreq_val & memreq_rdy;

    assign imemresp_msg = memresp_msg;
    assign dmemresp_msg = memresp_msg;

    always_comb begin
        imemresp_val = 1'b0;
        dmemresp_val = 1'b0;
        memresp_rdy  = 1'b0;
        if (!reset && !fifo_empty) begin
            if (head_id == REQ_DMEM) begin
                dmemresp_val = memresp_val;
                memresp_rdy  = dmemresp_rdy;
            end else begin
                imemresp_val = memresp_val;
                memresp_rdy  = imemresp_rdy;
            end
        end
    end

    assign resp_fire = memresp_val & memresp_rdy;

    always_comb begin
        prio_d  = prio_q;
        owner_d = owner_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (req_fire) begin
            owner_d[tail_q] = grant_dmem;
            tail_d          = tail_q + PtrBits'(1);
            prio_d          = grant_dmem ? REQ_IMEM : REQ_DMEM;
        end
        if (resp_fire) begin
            head_d = head_q + PtrBits'(1);
        end
        case ({req_fire, resp_fire})
            2'b10:   count_d = count_q + p_id_bits'(1);
            2'b01:   count_d = count_q - p_id_bits'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q  <= REQ_DMEM;
            owner_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            prio_q  <= prio_d;
            owner_q <= owner_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign inflight_count = count_q;

endmodule

// File: doc/proc_mem_port_arbiter.md
Name: proc_mem_port_arbiter

Overview:
- Shares one 4B memory request/response port between the processor's instruction-fetch (imem) and data (dmem) requesters.
- Requests are arbitrated round-robin and forwarded unchanged.
- A small ordering FIFO records which requester owns each in-flight request, and in-order responses are routed back by that record.
- Sits between the processor's imem/dmem bypass queues and a single-ported memory or cache.

Parameters:
p_max_inflight, 4, depth of the ordering FIFO = max outstanding requests; power of two, >=2
p_id_bits, $clog2(p_max_inflight)+1, width of inflight_count

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
imemreq_msg  input  77  mem_req_4B_t from fetch
imemreq_val  input  1  fetch request valid
imemreq_rdy  output  1  fetch request accepted
imemresp_msg  output  47  mem_resp_4B_t to fetch
imemresp_val  output  1  fetch response valid
imemresp_rdy  input  1  fetch ready for response
dmemreq_msg  input  77  mem_req_4B_t from data stage
dmemreq_val  input  1  data request valid
dmemreq_rdy  output  1  data request accepted
dmemresp_msg  output  47  mem_resp_4B_t to data stage
dmemresp_val  output  1  data response valid
dmemresp_rdy  input  1  data ready for response
memreq_msg  output  77  mem_req_4B_t to shared memory
memreq_val  output  1  shared request valid
memreq_rdy  input  1  memory accepts request
memresp_msg  input  47  mem_resp_4B_t from shared memory (in request order)
memresp_val  input  1  memory response valid
memresp_rdy  output  1  arbiter accepts response
inflight_count  output  p_id_bits  number of outstanding requests

Behaviour:
- Reset (async, immediate):
  - FIFO empty; inflight_count=0.
  - Round-robin pointer prio=DMEM.
  - While reset is high, all val/rdy outputs are 0.
- Grant (combinational, does not depend on memreq_rdy):
  - With FIFO full, no grant.
  - Otherwise, if only one requester is valid, it wins.
  - If both are valid, the requester named by prio wins.
- memreq_val=1 iff a grant exists. memreq_msg = the winner's msg, passed bit-exact (opaque untouched).
- Winner's req_rdy = memreq_rdy. Loser's req_rdy = 0.
- Request fire (memreq_val & memreq_rdy):
  - Push the winner id (0=imem, 1=dmem) into the FIFO.
  - prio <= the other requester.
  - With no fire, prio holds.
  - A single valid requester firing also flips prio.
- Response routing uses FIFO head id:
  - memresp_msg is broadcast to both resp_msg outputs.
  - Only the head's resp_val = memresp_val; the other is 0.
  - memresp_rdy = head requester's resp_rdy.
  - Response fire pops the FIFO.
- FIFO empty: memresp_rdy=0 and both resp_val=0. A response arriving in that state is a protocol violation; it is held off, never dropped silently.
- Full boundary:
  - When inflight_count==p_max_inflight, no grant, even if a pop occurs in the same cycle. There is no resp->req combinational path; issue resumes the next cycle.
- Simultaneous request fire and response pop: both take effect; inflight_count is unchanged; pointers advance mod p_max_inflight.
- FIFO pointers wrap modulo depth. Full/empty are distinguished by inflight_count.
- Latency: zero added cycles on both request and response paths (pure combinational forwarding plus FIFO bookkeeping).
- Reset mid-operation: in-flight records are discarded. The upstream drop logic is responsible for stale responses.

Test Plan:
- Only imem valid, addr 0x200, 0x204, 0x208, memreq_rdy=1 -> three forwarded back-to-back; inflight_count 1,2,3; the three responses appear on imemresp only, in order; dmemresp_val stays 0.
- Both valid every cycle from reset, memreq_rdy=1 -> grant order dmem, imem, dmem, imem; messages bit-exact, including opaque 0x5A.
- Both valid, memreq_rdy=0 for 3 cycles -> memreq_msg stays dmem's; prio unchanged; after rdy=1, dmem fires, then imem.
- Issue 4 requests with no responses (p_max_inflight=4) -> fifth stalls (memreq_val=0, both req_rdy=0); one response pop -> issue resumes the following cycle.
- Response for dmem at FIFO head with dmemresp_rdy=0 while imemresp_rdy=1 -> memresp_rdy=0; nothing pops until dmemresp_rdy=1.
- Assert reset with 3 in flight -> inflight_count=0 immediately; after release, next tie grants dmem first.
